// File: rtl/model_sample_aligner.sv
// model_sample_aligner: block-ring sample buffer that streams each completed block
// out once a release credit has been granted for it.
module model_sample_aligner #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_LOG2 = 12,
  parameter int NBLOCKS    = 2
) (
  input  logic                           iClock,
  input  logic                           iReset,
  input  logic                           iEnable,
  input  logic [WIDTH-1:0]               iSample,
  input  logic                           iSValid,
  input  logic                           iRelease,
  input  logic                           iReady,
  output logic [WIDTH-1:0]               oSample,
  output logic                           oValid,
  output logic                           oLast,
  output logic                           oFull,
  output logic [$clog2(NBLOCKS+1)-1:0]   oBlocks,
  output logic [1:0]                     oError
);
  localparam int PW = BLOCK_LOG2 + $clog2(NBLOCKS);
  localparam int BW = $clog2(NBLOCKS + 1);
  localparam logic [BW-1:0] NB = BW'(NBLOCKS);
  typedef enum logic {IDLE, STREAM} state_t;
  logic [WIDTH-1:0] mem [2**PW];
  state_t           state_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [BW-1:0]    blocks_q, blocks_d, credits_q, credits_d;
  logic [WIDTH-1:0] sample_q;
  logic             valid_q, last_q;
  logic [1:0]       err_q;
  logic             full, wr_ok, complete, rel_ok, xfer, drained, start, chain, fetch;
  // Complete blocks drain in write order, so the write slot is only blocked when every slot is complete.
  assign full     = blocks_q == NB;
  assign wr_ok    = iEnable && iSValid && !full;
  assign complete = wr_ok && &wr_ptr_q[BLOCK_LOG2-1:0];
  assign rel_ok   = iEnable && iRelease && credits_q != NB;
  assign xfer     = iEnable && valid_q && iReady;
  assign drained  = xfer && last_q;
  assign start    = iEnable && state_q == IDLE && credits_q != 0 && blocks_q != 0;
  // Next block is fetched in the same cycle the final sample leaves, so there is no bubble.
  assign chain    = drained && credits_q != 0 && blocks_q > 1;
  assign fetch    = start || chain || (state_q == STREAM && xfer && !last_q);
  assign blocks_d  = blocks_q + BW'(complete) - BW'(drained);
  assign credits_d = credits_q + BW'(rel_ok) - BW'(start || chain);
  always_ff @(posedge iClock)
    if (wr_ok) mem[wr_ptr_q] <= iSample;
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      blocks_q  <= '0;
      credits_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      blocks_q  <= blocks_d;
      credits_q <= credits_d;
      err_q     <= err_q | {iEnable && iRelease && credits_q == NB, iEnable && iSValid && full};
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fetch) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        sample_q <= mem[rd_ptr_q];
        valid_q  <= 1'b1;
        last_q   <= &rd_ptr_q[BLOCK_LOG2-1:0];
      end else if (xfer) begin
        valid_q  <= 1'b0;
        last_q   <= 1'b0;
      end
      if (start) state_q <= STREAM;
      else if (drained && !chain) state_q <= IDLE;
    end
  end
  assign oSample = sample_q;
  assign oValid  = valid_q;
  assign oLast   = last_q;
  assign oFull   = full;
  assign oBlocks = blocks_q;
  assign oError  = err_q;
endmodule

// File: tb/tb_model_sample_aligner.sv
// tb_model_sample_aligner: directed scoreboard bench for model_sample_aligner
// with 16-sample blocks and two slots.
module tb_model_sample_aligner;
  localparam int W = 16;
  logic          iClock = 1'b0, iReset = 1'b0, iEnable = 1'b1;
  logic [W-1:0]  iSample = '0;
  logic          iSValid = 1'b0, iRelease = 1'b0, iReady = 1'b1;
  logic [W-1:0]  oSample;
  logic          oValid, oLast, oFull;
  logic [1:0]    oBlocks, oError;
  logic [W:0]    exp_q[$];
  int            n_chk = 0, n_fail = 0;
  logic          prev_hold = 1'b0;
  logic [W-1:0]  prev_sample = '0;

  model_sample_aligner #(.WIDTH(W), .BLOCK_LOG2(4), .NBLOCKS(2)) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iSample(iSample),
    .iSValid(iSValid), .iRelease(iRelease), .iReady(iReady), .oSample(oSample),
    .oValid(oValid), .oLast(oLast), .oFull(oFull), .oBlocks(oBlocks), .oError(oError)
  );

  always #5 iClock = ~iClock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic do_reset();
    iReset = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    iReset = 1'b1;
    tick();
  endtask

  task automatic write_block(input int base);
    for (int i = 0; i < 16; i++) begin
      iSValid = 1'b1;
      iSample = W'(base + i);
      exp_q.push_back({i == 15, W'(base + i)});
      tick();
    end
    iSValid = 1'b0;
  endtask

  task automatic pulse_release();
    iRelease = 1'b1;
    tick();
    iRelease = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || oValid) && k < 300) begin
      tick();
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted transfer and checks that a stalled output holds.
  always @(negedge iClock) begin
    if (!iReset) prev_hold = 1'b0;
    else begin
      if (prev_hold) check("hold", {oValid, oSample}, {1'b1, prev_sample});
      if (oValid && iReady && iEnable) begin
        if (exp_q.size() == 0) check("unexpected_out", {oLast, oSample}, 32'hFFFF_FFFF);
        else check("out_sample", {oLast, oSample}, exp_q.pop_front());
      end
      prev_hold   = oValid && !(iReady && iEnable);
      prev_sample = oSample;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    do_reset();
    check("rst_valid", oValid, 0);
    check("rst_last", oLast, 0);
    check("rst_sample", oSample, 0);
    check("rst_full", oFull, 0);
    check("rst_blocks", oBlocks, 0);
    check("rst_error", oError, 0);
    // Block written first, released one cycle later.
    write_block(0);
    check("t1_blocks", oBlocks, 1);
    iRelease = 1'b1;
    tick();
    iRelease = 1'b0;
    check("t1_lat_early", oValid, 0);
    tick();
    check("t1_lat_valid", {oValid, oSample}, {1'b1, 16'd0});
    repeat (3) tick();
    iEnable = 1'b0;
    repeat (3) tick();
    iEnable = 1'b1;
    wait_drain("t1");
    check("t1_blocks_end", oBlocks, 0);
    // Credit arrives before the block is written.
    pulse_release();
    write_block(100);
    check("t2_lat_early", oValid, 0);
    tick();
    check("t2_lat_valid", {oValid, oSample}, {1'b1, 16'd100});
    check("t2_credits", dut.credits_q, 0);
    wait_drain("t2");
    // Two blocks with a stuttering consumer.
    iReady = 1'b0;
    write_block(200);
    write_block(216);
    check("t3_full", oFull, 1);
    pulse_release();
    pulse_release();
    for (int k = 0; k < 200 && (exp_q.size() != 0 || oValid); k++) begin
      iReady = ~iReady;
      tick();
    end
    iReady = 1'b1;
    check("t3_drained", exp_q.size(), 0);
    // Overflow: 33 writes, last one dropped.
    for (int i = 0; i < 33; i++) begin
      iSValid = 1'b1;
      iSample = W'(500 + i);
      if (i < 32) exp_q.push_back({i % 16 == 15, W'(500 + i)});
      tick();
      if (i == 31) check("t4_full", oFull, 1);
    end
    iSValid = 1'b0;
    check("t4_error", oError, 2'b01);
    check("t4_blocks", oBlocks, 2);
    iRelease = 1'b1;
    tick();
    tick();
    iRelease = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (oValid) cnt++;
      if (cnt > 0 && !oValid) break;
      tick();
    end
    check("t4_no_bubble", cnt, 32);
    check("t4_drained", exp_q.size(), 0);
    check("t4_blocks_end", oBlocks, 0);
    check("t4_error_sticky", oError, 2'b01);
    // Credit overflow.
    do_reset();
    repeat (3) pulse_release();
    tick();
    check("t5_error", oError, 2'b10);
    check("t5_credits", dut.credits_q, 2);
    check("t5_valid", oValid, 0);
    // Reset while streaming.
    do_reset();
    write_block(300);
    pulse_release();
    for (int k = 0; k < 50 && !(oValid && oSample == 16'd307); k++) tick();
    check("t6_reached_7", {oValid, oSample}, {1'b1, 16'd307});
    iReset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_outs", {oValid, oLast, oFull, oBlocks, oError, oSample}, 0);
    tick();
    iReset = 1'b1;
    tick();
    write_block(400);
    pulse_release();
    wait_drain("t6");
    check("t6_error", oError, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
